approx_mult_err_engine: RTL

Synthesizable on-FPGA error-characterization engine for the approximate multipliers. It sweeps every nonzero operand pair, drives the multiplier under test, and captures its product after a fixed latency. From that product it accumulates four metrics in hardware:
- error occurrences
- total error distance
- maximum error distance
- summed relative error distance scaled by 10000

It sits beside a multiplier instance (e.g. the 4x4 LM-family cores) so that characterization runs in silicon instead of in simulation.

---
 rtl/approx_mult_err_engine.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/approx_mult_err_engine.sv
// Error-characterization engine: sweeps all nonzero operand pairs through an attached
// multiplier and accumulates error count, distance, max distance and scaled relative error.
module approx_mult_err_engine #(
  parameter int W         = 4,
  parameter int LAT       = 0,
  parameter int RED_SCALE = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [2*W-1:0]   prod_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count,
  output logic [31:0]      err_dist,
  output logic [2*W-1:0]   max_err,
  output logic [31:0]      red_sum
);

  localparam int PW = 2 * W;
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [W-1:0] OP_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_CHECK, S_DIV, S_ACCUM, S_DONE
  } state_t;

  state_t r_state, w_state_next;

  logic [W-1:0]  r_a, r_b;
  logic [CW-1:0] r_lat_cnt;
  logic [PW-1:0] r_prod, r_ed, r_rem, r_max_err;
  logic [31:0]   r_quo, r_err_dist, r_red_sum;
  logic [4:0]    r_div_cnt;
  logic [15:0]   r_err_count;

  logic [PW-1:0] w_exact, w_ed, w_rem_next;
  logic [PW:0]   w_rem_shift, w_rem_sub;
  logic          w_qbit, w_lat_last, w_last_pair;
  logic [32:0]   w_red_add;
  logic [31:0]   w_red_next;

  assign w_exact     = PW'(r_a) * PW'(r_b);
  assign w_ed        = (r_prod >= w_exact) ? (r_prod - w_exact) : (w_exact - r_prod);
  assign w_lat_last  = (r_lat_cnt == CW'(LAT));
  assign w_last_pair = (r_a == OP_MAX) && (r_b == OP_MAX);

  // Restoring divider step: the dividend shifts out of r_quo while quotient bits shift in.
  assign w_rem_shift = {r_rem, r_quo[31]};
  assign w_rem_sub   = w_rem_shift - {1'b0, w_exact};
  assign w_qbit      = (w_rem_shift >= {1'b0, w_exact});
  assign w_rem_next  = w_qbit ? w_rem_sub[PW-1:0] : w_rem_shift[PW-1:0];

  assign w_red_add   = {1'b0, r_red_sum} + {1'b0, r_quo};
  assign w_red_next  = w_red_add[32] ? 32'hFFFF_FFFF : w_red_add[31:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_DRIVE;
      S_DRIVE: begin
        busy = 1'b1;
        if (w_lat_last) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        busy         = 1'b1;
        w_state_next = (w_ed == '0) ? S_ACCUM : S_DIV;
      end
      S_DIV: begin
        busy = 1'b1;
        if (r_div_cnt == 5'd31) w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        busy         = 1'b1;
        w_state_next = w_last_pair ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_state_next = S_DRIVE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_lat_cnt   <= '0;
      r_prod      <= '0;
      r_ed        <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div_cnt   <= '0;
      r_err_count <= '0;
      r_err_dist  <= '0;
      r_max_err   <= '0;
      r_red_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a         <= W'(1);
            r_b         <= W'(1);
            r_lat_cnt   <= '0;
            r_err_count <= '0;
            r_err_dist  <= '0;
            r_max_err   <= '0;
            r_red_sum   <= '0;
          end
        end
        S_DRIVE: begin
          if (w_lat_last) begin
            r_prod    <= prod_in;
            r_lat_cnt <= '0;
          end else begin
            r_lat_cnt <= r_lat_cnt + CW'(1);
          end
        end
        S_CHECK: begin
          r_ed      <= w_ed;
          r_quo     <= 32'(w_ed) * 32'(RED_SCALE);
          r_rem     <= '0;
          r_div_cnt <= '0;
        end
        S_DIV: begin
          r_rem     <= w_rem_next;
          r_quo     <= {r_quo[30:0], w_qbit};
          r_div_cnt <= r_div_cnt + 5'd1;
        end
        S_ACCUM: begin
          if (r_ed != '0) begin
            r_err_count <= r_err_count + 16'd1;
            r_err_dist  <= r_err_dist + 32'(r_ed);
            r_red_sum   <= w_red_next;
            if (r_ed > r_max_err) r_max_err <= r_ed;
          end
          // Operands stay on the final pair once the sweep ends.
          if (!w_last_pair) begin
            if (r_b == OP_MAX) begin
              r_b <= W'(1);
              r_a <= r_a + W'(1);
            end else begin
              r_b <= r_b + W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign op_a      = r_a;
  assign op_b      = r_b;
  assign err_count = r_err_count;
  assign err_dist  = r_err_dist;
  assign max_err   = r_max_err;
  assign red_sum   = r_red_sum;

endmodule
